// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: default sizes, FSM encoding, arctangent table, saturation decision.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cordic_pkg;

    localparam int BITS_DEF   = 16;
    localparam int STAGES_DEF = 12;
    // Widest BITS the saturation helper is sized for.
    localparam int MAXW       = 32;

    localparam logic [MAXW+1:0] SAT_ONE = (MAXW+2)'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_HI   = 2'd1,
        SAT_LO   = 2'd2
    } sat_t;

    // atan(2^-i) with +/-pi mapped to +/-2^(bits-1). The table is exact for
    // 16-bit angles; other widths are derived by shifting (rounded when narrowing).
    function automatic int atan_val(input int i, input int bits);
        int a16;
        case (i)
            0:       a16 = 8192;
            1:       a16 = 4836;
            2:       a16 = 2555;
            3:       a16 = 1297;
            4:       a16 = 651;
            5:       a16 = 326;
            6:       a16 = 163;
            7:       a16 = 81;
            8:       a16 = 41;
            9:       a16 = 20;
            10:      a16 = 10;
            11:      a16 = 5;
            12:      a16 = 3;
            13:      a16 = 1;
            default: a16 = 0;
        endcase
        if (bits >= 16) begin
            return a16 << (bits - 16);
        end
        return (a16 + (1 << (15 - bits))) >> (16 - bits);
    endfunction

    // Decide whether a wide signed value fits a signed 'bits'-wide word,
    // and which rail to clip to if not.
    function automatic sat_t sat_clip(input logic signed [MAXW+1:0] v, input int bits);
        logic signed [MAXW+1:0] hi;
        logic signed [MAXW+1:0] lo;
        hi = $signed((SAT_ONE << (bits - 1)) - SAT_ONE);
        lo = ~hi;
        if (v > hi) begin
            return SAT_HI;
        end
        if (v < lo) begin
            return SAT_LO;
        end
        return SAT_NONE;
    endfunction

endpackage

// File: rtl/cordic_iter_ctrl_if.sv
// Job handshake bundle for the iterative CORDIC: start/flush request side, ready/valid result side.
// Latency: n/a (wires only).
// Backpressure: start is only honoured while ready is high; results are a one-cycle valid pulse.
interface cordic_iter_ctrl_if #(parameter int BITS = cordic_pkg::BITS_DEF);
    logic                   start;
    logic                   flush;
    logic signed [BITS-1:0] xi;
    logic signed [BITS-1:0] yi;
    logic signed [BITS-1:0] zi;
    logic                   ready;
    logic                   valid;
    logic signed [BITS-1:0] xo;
    logic signed [BITS-1:0] yo;
    logic signed [BITS-1:0] zo;

    modport master (output start, flush, xi, yi, zi, input  ready, valid, xo, yo, zo);
    modport slave  (input  start, flush, xi, yi, zi, output ready, valid, xo, yo, zo);
endinterface

// File: rtl/cordic_iter_step.sv
// One CORDIC micro-rotation, steering direction taken from the sign of the residual angle.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module cordic_iter_step #(
    parameter int BITS = 16,
    parameter int IW   = 4
) (
    input  logic signed [BITS+1:0] x,
    input  logic signed [BITS+1:0] y,
    input  logic signed [BITS-1:0] z,
    input  logic        [IW-1:0]   i,
    input  logic signed [BITS-1:0] atan,
    output logic signed [BITS+1:0] x_n,
    output logic signed [BITS+1:0] y_n,
    output logic signed [BITS-1:0] z_n
);

    logic signed [BITS+1:0] xs;
    logic signed [BITS+1:0] ys;

    assign xs = x >>> i;
    assign ys = y >>> i;

    // Rotate towards zero residual angle; z wraps naturally at BITS.
    always_comb begin
        x_n = x;
        y_n = y;
        z_n = z;
        if (z >= 0) begin
            x_n = x - ys;
            y_n = y + xs;
            z_n = z - atan;
        end else begin
            x_n = x + ys;
            y_n = y - xs;
            z_n = z + atan;
        end
    end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Iterative rotation-mode CORDIC: one shared micro-rotation per cycle, saturated outputs, no gain fix-up.
// Latency: valid pulses STAGES+1 edges after the edge that accepted start; next start one edge later.
// Backpressure: ready only in IDLE; start while busy is dropped, flush aborts without a result.
module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter int BITS   = BITS_DEF,
    parameter int STAGES = STAGES_DEF
) (
    input  logic              clock,
    input  logic              reset,
    cordic_iter_ctrl_if.slave bus
);

    localparam int IW = 4;
    localparam logic signed [BITS-1:0] POS_MAX = {1'b0, {(BITS-1){1'b1}}};
    localparam logic signed [BITS-1:0] NEG_MAX = {1'b1, {(BITS-1){1'b0}}};

    state_t                 state;
    state_t                 state_nx;
    logic signed [BITS+1:0] x_q;
    logic signed [BITS+1:0] y_q;
    logic signed [BITS-1:0] z_q;
    logic        [IW-1:0]   i_q;
    logic signed [BITS+1:0] x_n;
    logic signed [BITS+1:0] y_n;
    logic signed [BITS-1:0] z_n;
    logic signed [BITS-1:0] atan_i;
    logic signed [BITS-1:0] x_sat;
    logic signed [BITS-1:0] y_sat;
    logic                   accept;
    logic                   last;
    logic                   load_out;

    // flush outranks start so an aborting caller never launches a job
    assign accept = (state == ST_IDLE) && bus.start && !bus.flush;
    assign last   = (i_q == IW'(STAGES - 1));
    assign atan_i = BITS'(atan_val(int'(i_q), BITS));

    cordic_iter_step #(.BITS(BITS), .IW(IW)) u_step (
        .x    (x_q),
        .y    (y_q),
        .z    (z_q),
        .i    (i_q),
        .atan (atan_i),
        .x_n  (x_n),
        .y_n  (y_n),
        .z_n  (z_n)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: one rotation per RUN cycle, a single DONE cycle, flush returns to IDLE
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = ST_RUN;
            ST_RUN:  if (bus.flush) state_nx = ST_IDLE;
                     else if (last) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake ready and the result-load strobe
    always_comb begin
        bus.ready = (state == ST_IDLE);
        load_out  = (state == ST_DONE) && !bus.flush;
    end

    // Working vector: capture on accept, rotate while running
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
            i_q <= '0;
        end else if (accept) begin
            x_q <= (BITS+2)'(bus.xi);
            y_q <= (BITS+2)'(bus.yi);
            z_q <= bus.zi;
            i_q <= '0;
        end else if (state == ST_RUN && !bus.flush) begin
            x_q <= x_n;
            y_q <= y_n;
            z_q <= z_n;
            if (!last) begin
                i_q <= i_q + IW'(1);
            end
        end
    end

    // Clip the guard-bit vector back to BITS
    always_comb begin
        case (sat_clip((MAXW+2)'(x_q), BITS))
            SAT_HI:  x_sat = POS_MAX;
            SAT_LO:  x_sat = NEG_MAX;
            default: x_sat = x_q[BITS-1:0];
        endcase
        case (sat_clip((MAXW+2)'(y_q), BITS))
            SAT_HI:  y_sat = POS_MAX;
            SAT_LO:  y_sat = NEG_MAX;
            default: y_sat = y_q[BITS-1:0];
        endcase
    end

    // Result registers hold between jobs; valid is a single-cycle pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.valid <= 1'b0;
            bus.xo    <= '0;
            bus.yo    <= '0;
            bus.zo    <= '0;
        end else begin
            bus.valid <= load_out;
            if (load_out) begin
                bus.xo <= x_sat;
                bus.yo <= y_sat;
                bus.zo <= z_q;
            end
        end
    end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed bench for cordic_iter_ctrl: vector table plus handshake, flush and reset sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_cordic_iter_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    cordic_iter_ctrl_if #(.BITS(16)) bus ();

    cordic_iter_ctrl #(.BITS(16), .STAGES(12)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int xi;
        int yi;
        int zi;
        int ax;
        int ay;
        int tol;
    } vec_t;

    vec_t vecs[8];
    int   atan_tab[14] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1};
    int   n_checks = 0;
    int   n_fail   = 0;
    int   last_x   = 0;
    int   last_y   = 0;
    int   last_z   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input int act, input int exp, input int tol);
        int d;
        n_checks++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference recurrence: 12 micro-rotations, 16-bit wrapped angle, saturated outputs
    function automatic void ref_cordic(input int xi, input int yi, input int zi,
                                       output int xo, output int yo, output int zo);
        int x, y, z, xn, yn;
        logic signed [15:0] zw;
        x = xi; y = yi; z = zi;
        for (int i = 0; i < 12; i++) begin
            if (z >= 0) begin
                xn = x - (y >>> i);
                yn = y + (x >>> i);
                z  = z - atan_tab[i];
            end else begin
                xn = x + (y >>> i);
                yn = y - (x >>> i);
                z  = z + atan_tab[i];
            end
            x  = xn;
            y  = yn;
            zw = 16'(z);
            z  = zw;
        end
        xo = sat16(x);
        yo = sat16(y);
        zo = z;
    endfunction

    // Caller is at a negedge with the DUT idle; start is pulsed for one edge
    task automatic do_job(input int xi, input int yi, input int zi, input string tag);
        int lat, ex, ey, ez;
        ref_cordic(xi, yi, zi, ex, ey, ez);
        bus.xi    = 16'(xi);
        bus.yi    = 16'(yi);
        bus.zi    = 16'(zi);
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        check({tag, "_busy"}, int'(bus.ready), 0);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock);
            #1;
            if (bus.valid) begin
                lat = n;
                break;
            end
        end
        check({tag, "_latency"}, lat, 13);
        check({tag, "_ready_at_valid"}, int'(bus.ready), 1);
        check({tag, "_xo"}, int'(bus.xo), ex);
        check({tag, "_yo"}, int'(bus.yo), ey);
        check({tag, "_zo"}, int'(bus.zo), ez);
        last_x = ex;
        last_y = ey;
        last_z = ez;
        @(posedge clock);
        #1;
        check({tag, "_valid_one_cycle"}, int'(bus.valid), 0);
    endtask

    task automatic count_valids(input int cycles, output int cnt);
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clock);
            #1;
            if (bus.valid) cnt++;
        end
    endtask

    task automatic check_held(input string tag);
        check({tag, "_xo_held"}, int'(bus.xo), last_x);
        check({tag, "_yo_held"}, int'(bus.yo), last_y);
        check({tag, "_zo_held"}, int'(bus.zo), last_z);
    endtask

    initial begin
        int cnt;
        int vt[$];

        vecs[0] = '{16000,      0,     0,  26349,      0,  8};
        vecs[1] = '{10000,      0,  8192,  11645,  11645,  8};
        vecs[2] = '{10000,      0, -8192,  11645, -11645,  8};
        vecs[3] = '{    0,  16000,     0,      0,  26349, 12};
        vecs[4] = '{10000,      0, 16384,      0,  16468, 12};
        vecs[5] = '{-12000,  5000,  4000, -21407,    242, 16};
        vecs[6] = '{32767,  32767,     0,  32767,  32767,  0};
        vecs[7] = '{-32768, -32768,    0, -32768, -32768,  0};

        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.xi    = '0;
        bus.yi    = '0;
        bus.zi    = '0;

        // Reset state
        #12;
        check("rst_ready", int'(bus.ready), 1);
        check("rst_valid", int'(bus.valid), 0);
        check("rst_xo", int'(bus.xo), 0);
        check("rst_yo", int'(bus.yo), 0);
        check("rst_zo", int'(bus.zo), 0);

        // Table: first job starts in the same cycle as reset release
        @(negedge clock);
        reset = 1'b1;
        for (int v = 0; v < 8; v++) begin
            if (v != 0) @(negedge clock);
            do_job(vecs[v].xi, vecs[v].yi, vecs[v].zi, $sformatf("vec%0d", v));
            check_tol($sformatf("vec%0d_x_analytic", v), int'(bus.xo), vecs[v].ax, vecs[v].tol);
            check_tol($sformatf("vec%0d_y_analytic", v), int'(bus.yo), vecs[v].ay, vecs[v].tol);
        end

        // start held high: accepts every 14 edges, start during RUN ignored
        @(negedge clock);
        bus.xi    = 16'(10000);
        bus.yi    = 16'(0);
        bus.zi    = 16'(8192);
        bus.start = 1'b1;
        for (int c = 0; c <= 70; c++) begin
            @(posedge clock);
            #1;
            if (c == 44) bus.start = 1'b0;
            if (c == 5) check("cont_ready_in_run", int'(bus.ready), 0);
            if (bus.valid) vt.push_back(c);
        end
        check("cont_valid_count", vt.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < vt.size()) check($sformatf("cont_valid_at_%0d", k), vt[k], 13 + 14 * k);
        end
        ref_cordic(10000, 0, 8192, last_x, last_y, last_z);
        check_held("cont");

        // flush at RUN iteration 5
        @(negedge clock);
        bus.xi    = 16'(16000);
        bus.yi    = 16'(0);
        bus.zi    = 16'(0);
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        bus.flush = 1'b1;
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        check("flush_run_ready", int'(bus.ready), 1);
        check("flush_run_valid", int'(bus.valid), 0);
        check_held("flush_run");
        count_valids(20, cnt);
        check("flush_run_no_valid", cnt, 0);

        // flush together with start in IDLE
        @(negedge clock);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_idle_not_accepted", int'(bus.ready), 1);
        count_valids(20, cnt);
        check("flush_idle_no_valid", cnt, 0);

        // flush in the DONE cycle suppresses the result
        @(negedge clock);
        bus.xi    = 16'(10000);
        bus.yi    = 16'(0);
        bus.zi    = 16'(-8192);
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        check("done_not_ready", int'(bus.ready), 0);
        @(negedge clock);
        bus.flush = 1'b1;
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        check("flush_done_valid", int'(bus.valid), 0);
        check("flush_done_ready", int'(bus.ready), 1);
        check_held("flush_done");
        count_valids(20, cnt);
        check("flush_done_no_valid", cnt, 0);

        // reset pulsed mid-RUN
        @(negedge clock);
        bus.xi    = 16'(-12000);
        bus.yi    = 16'(5000);
        bus.zi    = 16'(4000);
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_xo", int'(bus.xo), 0);
        check("midrst_yo", int'(bus.yo), 0);
        check("midrst_zo", int'(bus.zo), 0);
        check("midrst_ready", int'(bus.ready), 1);
        check("midrst_valid", int'(bus.valid), 0);
        @(negedge clock);
        reset = 1'b1;
        count_valids(20, cnt);
        check("midrst_no_valid", cnt, 0);
        @(negedge clock);
        do_job(10000, 0, 8192, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_iter_ctrl.md
CORDIC_ITER_CTRL -- requirements
Module: cordic_iter_ctrl

Interface
REQ-001 Parameter BITS, default 16: signed width of the x/y/z inputs and outputs.
REQ-002 Parameter STAGES, default 12, legal range 4..14: number of CORDIC micro-rotations per job.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted low.
REQ-005 start  input  1  job request; sampled only while ready=1.
REQ-006 flush  input  1  synchronous abort of the job in progress.
REQ-007 xi, yi  input  BITS  signed input vector, captured on an accepted start.
REQ-008 zi  input  BITS  signed angle, captured on an accepted start; full scale +/-pi = +/-2^(BITS-1).
REQ-009 ready  output  1  high when idle and able to accept start.
REQ-010 valid  output  1  one-cycle pulse marking xo/yo/zo as new.
REQ-011 xo, yo  output  BITS  signed rotated vector, saturated.
REQ-012 zo  output  BITS  signed residual angle.

Function
REQ-013 States: IDLE, RUN, DONE; reset enters IDLE.
REQ-014 IDLE to RUN on start=1, with: xi/yi sign-extended to BITS+2 into x/y; zi into z; iteration counter i cleared to 0.
REQ-015 RUN performs one micro-rotation per cycle using the shared iteration sub-module.
REQ-016 Micro-rotation when z>=0: x'=x-(y>>>i), y'=y+(x>>>i), z'=z-ATAN[i].
REQ-017 Micro-rotation when z<0: x'=x+(y>>>i), y'=y-(x>>>i), z'=z+ATAN[i].
REQ-018 Shifts are arithmetic. z arithmetic wraps modulo 2^BITS.
REQ-019 RUN to DONE after the rotation with i=STAGES-1; otherwise i increments by 1.
REQ-020 DONE: xo/yo load x/y saturated to [-2^(BITS-1), 2^(BITS-1)-1]; zo loads z; valid=1 for exactly this one cycle; next state IDLE.
REQ-021 Latency: valid is high in the cycle following rising edge k+STAGES+1, where k is the edge that sampled start; the next start is accepted at edge k+STAGES+2.
REQ-022 ready=1 only in IDLE. start while ready=0 is ignored; it is neither queued nor counted.
REQ-023 flush=1 in RUN or DONE forces IDLE on the next edge, with no valid pulse and xo/yo/zo unchanged.
REQ-024 flush=1 together with start in IDLE: flush wins and no job is accepted.
REQ-025 xo/yo/zo hold their last value between jobs.
REQ-026 No gain compensation: the output magnitude includes the CORDIC gain (about 1.6468 for STAGES>=10).
REQ-027 ATAN[i] = round(atan(2^-i) * 2^(BITS-1)/pi). For BITS=16: 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1.
REQ-028 Callers restrict inputs to |zi| <= pi/2 (16384 for BITS=16); behaviour outside this range is not specified.

Reset
REQ-029 With reset low, asynchronously: state=IDLE, i=0, ready=1, valid=0, xo=yo=zo=0, internal x/y/z=0.
REQ-030 Reset asserted mid-job discards the job; no valid pulse follows reset release.
REQ-031 The first start is accepted on the first rising edge after reset release.

Structure
REQ-032 The shared cordic_pkg holds: BITS/STAGES defaults, the ATAN table function or constant, the state encoding, and the saturation function.
REQ-033 Sub-module cordic_iter_step is combinational: inputs x, y, z, i, atan; outputs x', y', z'. The controller registers all state.
REQ-034 Exactly one cordic_iter_step instance exists; no unrolled stages.

Verification
REQ-035 Reset, then xi=16000, yi=0, zi=0, start for 1 cycle -> valid exactly 13 edges later; xo=26349+/-4, yo=0+/-4, |zo|<=2.
REQ-036 xi=10000, yi=0, zi=8192 -> xo=11645+/-4, yo=11645+/-4.
REQ-037 xi=32767, yi=32767, zi=0 -> xo=yo=32767 (saturated); xi=yi=-32768 -> xo=yo=-32768.
REQ-038 start held high continuously -> jobs accepted every 14 cycles; start pulses during RUN are ignored; one valid per accepted job.
REQ-039 flush at RUN iteration 5 -> no valid, outputs unchanged, ready=1 next cycle; flush with start in IDLE -> no job accepted.
REQ-040 reset pulsed low mid-RUN -> all outputs 0 immediately, no valid afterwards; a new job after release produces a correct result.
